vco_band_cal: RTL and testbench

VCO_BAND_CAL -- requirements
Module: vco_band_cal

---
 rtl/vco_band_cal_pkg.sv | 23 ++
 rtl/vco_edge_counter.sv | 27 ++
 rtl/vco_band_cal.sv | 157 +++++++++++++++
 tb/tb_vco_band_cal.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vco_band_cal_pkg.sv
// rtl/vco_band_cal_pkg.sv - shared types and constants for the VCO coarse band calibrator
package vco_band_cal_pkg;

    localparam int TUNE_W = 5;
    localparam logic [TUNE_W-1:0] TUNE_MID = 5'd15;
    localparam logic [TUNE_W-1:0] TUNE_MSB = 5'b10000;

    localparam int DEF_WIN_CYCLES    = 1000;
    localparam int DEF_SETTLE_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DECIDE,
        ST_DONE
    } cal_state_e;

    function automatic logic [TUNE_W-1:0] bit_mask(input logic [2:0] idx);
        return TUNE_W'(1) << idx;
    endfunction

endpackage

// File: rtl/vco_edge_counter.sv
// rtl/vco_edge_counter.sv - saturating counter of VCO edge ticks within a measurement window
module vco_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && tick_i && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vco_band_cal.sv
// rtl/vco_band_cal.sv - binary-search coarse tune calibration of a VCO against a target edge count
module vco_band_cal
    import vco_band_cal_pkg::*;
#(
    parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = 16,
    parameter int TOL           = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              vco_tick,
    input  logic [CNT_W-1:0]  target_cnt,
    output logic [TUNE_W-1:0] tune,
    output logic              busy,
    output logic              done,
    output logic              cal_fail,
    output logic [CNT_W-1:0]  final_cnt
);

    localparam int CYC_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = (CYC_MAX > 2) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOL_C       = CNT_W'(TOL);

    cal_state_e        state_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [2:0]        bit_q;
    logic [TUNE_W-1:0] result_q;
    logic [CNT_W-1:0]  target_q;
    logic              verify_q;
    logic [TUNE_W-1:0] tune_q;
    logic              busy_q;
    logic              done_q;
    logic              fail_q;
    logic [CNT_W-1:0]  final_q;

    logic              cnt_clear;
    logic              cnt_en;
    logic [CNT_W-1:0]  meas_cnt;
    logic [TUNE_W-1:0] result_d;
    logic [CNT_W-1:0]  diff_d;
    logic              fail_d;

    // The count is cleared on the last SETTLE cycle so MEASURE starts from zero.
    assign cnt_clear = (state_q == ST_SETTLE) && (cyc_q == SETTLE_LAST);
    assign cnt_en    = (state_q == ST_MEASURE);

    vco_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (cnt_clear),
        .enable_i (cnt_en),
        .tick_i   (vco_tick),
        .count_o  (meas_cnt)
    );

    always_comb begin
        result_d = result_q;
        if (meas_cnt <= target_q) begin
            result_d = result_q | bit_mask(bit_q);
        end
        diff_d = (meas_cnt >= target_q) ? (meas_cnt - target_q) : (target_q - meas_cnt);
        fail_d = (diff_d > TOL_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            result_q <= '0;
            target_q <= '0;
            verify_q <= 1'b0;
            tune_q   <= TUNE_MID;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            final_q  <= '0;
        end else if (abort) begin
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            verify_q <= 1'b0;
            tune_q   <= TUNE_MID;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_SETTLE;
                        cyc_q    <= '0;
                        target_q <= target_cnt;
                        result_q <= '0;
                        bit_q    <= 3'd4;
                        verify_q <= 1'b0;
                        tune_q   <= TUNE_MSB;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cyc_q == SETTLE_LAST) begin
                        cyc_q   <= '0;
                        state_q <= ST_MEASURE;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (cyc_q == WIN_LAST) begin
                        cyc_q   <= '0;
                        state_q <= ST_DECIDE;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (verify_q) begin
                        final_q <= meas_cnt;
                        fail_q  <= fail_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        // Keep the trial bit when the VCO is not yet faster than the target.
                        result_q <= result_d;
                        state_q  <= ST_SETTLE;
                        if (bit_q != 3'd0) begin
                            bit_q  <= bit_q - 3'd1;
                            tune_q <= result_d | bit_mask(bit_q - 3'd1);
                        end else begin
                            verify_q <= 1'b1;
                            tune_q   <= result_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tune      = tune_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cal_fail  = fail_q;
    assign final_cnt = final_q;

endmodule

// File: tb/tb_vco_band_cal.sv
// tb/tb_vco_band_cal.sv - self-checking bench for vco_band_cal with a behavioural VCO and SAR model
module tb_vco_band_cal;

    localparam int S = 64;
    localparam int W = 1000;
    localparam int P = S + W + 1;
    localparam int S2 = 4;
    localparam int W2 = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        vco_tick = 1'b0;
    logic [15:0] target_cnt = '0;
    logic [4:0]  tune;
    logic        busy, done, cal_fail;
    logic [15:0] final_cnt;

    logic        start2 = 1'b0;
    logic [7:0]  target2 = '0;
    logic [4:0]  tune2;
    logic        busy2, done2, fail2;
    logic [7:0]  final2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vco_band_cal dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vco_tick(vco_tick),
        .target_cnt(target_cnt), .tune(tune), .busy(busy), .done(done),
        .cal_fail(cal_fail), .final_cnt(final_cnt)
    );

    vco_band_cal #(.WIN_CYCLES(W2), .SETTLE_CYCLES(S2), .CNT_W(8), .TOL(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .vco_tick(1'b1),
        .target_cnt(target2), .tune(tune2), .busy(busy2), .done(done2),
        .cal_fail(fail2), .final_cnt(final2)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // VCO: f = 7 MHz + (tune-15)*100 kHz sampled by a 100 MHz clock (phase in units of 100 kHz).
    int ph = 0;
    always @(negedge clk) begin
        ph += 70 + (int'(tune) - 15);
        if (ph >= 1000) begin
            ph -= 1000;
            vco_tick = 1'b1;
        end else begin
            vco_tick = 1'b0;
        end
    end

    function automatic int vco_cnt(input int t);
        return 70 + (t - 15);
    endfunction

    // Model: a calibration is a timeline of six passes of P cycles over a precomputed code plan.
    bit          m_active = 0;
    int          m_n = 0;
    int          m_codes[6];
    int          m_tune = 15;
    bit          m_done = 0;
    bit          m_fail = 0;
    int          m_fcnt = 0;
    int          m_tgt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_tune = 15; m_fail = 0; m_fcnt = 0;
        end else if (abort) begin
            m_active = 0; m_done = 0; m_tune = 15; m_fail = 0;
        end else if (m_active) begin
            m_n++;
            if (m_n == 6 * P) begin
                int d;
                m_active = 0;
                m_done = 1;
                m_fcnt = vco_cnt(m_codes[5]);
                d = m_fcnt - m_tgt;
                if (d < 0) d = -d;
                m_fail = (d > 2);
            end else begin
                m_tune = m_codes[m_n / P];
            end
        end else if (start) begin
            int res;
            m_tgt = int'(target_cnt);
            res = 0;
            for (int i = 4; i >= 0; i--) begin
                int tr;
                tr = res | (1 << i);
                m_codes[4 - i] = tr;
                if (vco_cnt(tr) <= m_tgt) res = tr;
            end
            m_codes[5] = res;
            m_active = 1; m_n = 0; m_done = 0; m_tune = m_codes[0];
        end
    end

    always @(negedge clk) begin
        chk("cyc_tune", tune, m_tune);
        chk("cyc_busy", busy, m_active);
        chk("cyc_done", done, m_done);
        chk("cyc_fail", cal_fail, m_fail);
        chk("cyc_final", final_cnt, m_fcnt);
    end

    task automatic run_cal(input int tgt, input int poke, output int lat);
        int n;
        @(negedge clk);
        target_cnt = 16'(tgt);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 7000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == poke) begin
                target_cnt = 16'd10;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        // done rises at edge k+n and is first sampled by the following edge.
        lat = n + 1;
    endtask

    task automatic run_cal2(input int tgt);
        int n;
        @(negedge clk);
        target2 = 8'(tgt);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 3000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!done2) chk("done8_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tune", tune, 15);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_final", final_cnt, 0);
        chk("rst_tune8", tune2, 15);
        rst_n = 1'b1;

        run_cal(74, -1, lat);
        chk("t74_lat", lat, 6391);
        chk("t74_tune", tune, 19);
        chk("t74_final", final_cnt, 74);
        chk("t74_fail", cal_fail, 0);
        chk("t74_done", done, 1);
        chk("plan_c0", m_codes[0], 16);
        chk("plan_c1", m_codes[1], 24);
        chk("plan_c2", m_codes[2], 20);
        chk("plan_c3", m_codes[3], 18);
        chk("plan_c4", m_codes[4], 19);

        run_cal(200, -1, lat);
        chk("t200_tune", tune, 31);
        chk("t200_final", final_cnt, 86);
        chk("t200_fail", cal_fail, 1);

        run_cal(10, -1, lat);
        chk("t10_lat", lat, 6391);
        chk("t10_tune", tune, 0);
        chk("t10_final", final_cnt, 55);
        chk("t10_fail", cal_fail, 1);

        @(negedge clk);
        target_cnt = 16'd74;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2 * P + S + 10) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tune", tune, 15);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_tune", tune, 15);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_busy", busy, 0);

        @(negedge clk);
        target_cnt = 16'd74;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tune", tune, 15);
        chk("arst_busy", busy, 0);
        chk("arst_final", final_cnt, 0);
        chk("arst_fail", cal_fail, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("arst_noresume", busy, 0);

        run_cal(74, 300, lat);
        chk("poke_tune", tune, 19);
        chk("poke_final", final_cnt, 74);
        chk("poke_fail", cal_fail, 0);
        chk("poke_lat", lat, 6391);

        run_cal2(250);
        chk("sat250_tune", tune2, 0);
        chk("sat250_final", final2, 255);
        chk("sat250_fail", fail2, 1);
        run_cal2(255);
        chk("sat255_tune", tune2, 31);
        chk("sat255_final", final2, 255);
        chk("sat255_fail", fail2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
